// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
// Holds the clear-FSM state enum, default widths and depth computation.
package rf_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W_DEF = 32;
  localparam int RF_ADDR_W_DEF = 5;
  localparam int RF_NUM_RD_DEF = 2;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: read ports, two write ports, reserve and clear control.
// Reads are combinational; the upstream side stalls on clr_busy.
interface reg_file_mp_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W_DEF,
  parameter int ADDR_W = RF_ADDR_W_DEF,
  parameter int NUM_RD = RF_NUM_RD_DEF
) ();

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pend;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     resv_en;
  logic [ADDR_W-1:0]        resv_addr;
  logic                     clr_req;
  logic                     clr_busy;

  modport master (
    output rd_addr,
    input  rd_data,
    input  rd_pend,
    output wr0_en,
    output wr0_addr,
    output wr0_data,
    output wr1_en,
    output wr1_addr,
    output wr1_data,
    output resv_en,
    output resv_addr,
    output clr_req,
    input  clr_busy
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    output rd_pend,
    input  wr0_en,
    input  wr0_addr,
    input  wr0_data,
    input  wr1_en,
    input  wr1_addr,
    input  wr1_data,
    input  resv_en,
    input  resv_addr,
    input  clr_req,
    output clr_busy
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: decode, write-bypass priority mux, r0 and pending gating.
// Zero latency; write/reserve enables arrive pre-gated so bypass is inert during clear.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W_DEF,
  parameter int ADDR_W  = RF_ADDR_W_DEF,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1,
  parameter int DEPTH   = rf_depth(ADDR_W)
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  input  logic [DEPTH-1:0]              pend_vec,
  input  logic                          wr0_en,
  input  logic [ADDR_W-1:0]             wr0_addr,
  input  logic [DATA_W-1:0]             wr0_data,
  input  logic                          wr1_en,
  input  logic [ADDR_W-1:0]             wr1_addr,
  input  logic [DATA_W-1:0]             wr1_data,
  input  logic                          resv_en,
  input  logic [ADDR_W-1:0]             resv_addr,
  output logic [DATA_W-1:0]             data,
  output logic                          pend
);

  logic hit0, hit1, hit_resv;

  assign hit0     = wr0_en  && (wr0_addr  == addr);
  assign hit1     = wr1_en  && (wr1_addr  == addr);
  assign hit_resv = resv_en && (resv_addr == addr);

  always_comb begin
    data = mem[addr];
    pend = pend_vec[addr];
    // A bypassed value is about to be committed, so it is only pending if re-reserved now
    if (BYPASS != 0) begin
      if (hit1) begin
        data = wr1_data;
        pend = hit_resv;
      end else if (hit0) begin
        data = wr0_data;
        pend = hit_resv;
      end
    end
    if ((ZERO_R0 != 0) && (addr == '0)) begin
      data = '0;
      pend = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with r0-zero, write bypass, pending scoreboard and bulk-clear engine.
// Reads combinational, writes at the edge; clear takes DEPTH cycles with clr_busy high.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W_DEF,
  parameter int ADDR_W  = RF_ADDR_W_DEF,
  parameter int NUM_RD  = RF_NUM_RD_DEF,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = rf_depth(ADDR_W);

  rf_state_e                   state_q, state_d;
  logic [ADDR_W-1:0]           idx_q, idx_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]            pend_q;
  logic                        busy;
  logic                        wr0_ok, wr1_ok, resv_ok;

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  assign busy         = (state_q == RF_CLEAR);
  assign bus.clr_busy = busy;

  // Gating here also disables bypass in the read ports while clearing
  assign wr0_ok  = bus.wr0_en  && !busy && !is_r0(bus.wr0_addr);
  assign wr1_ok  = bus.wr1_en  && !busy && !is_r0(bus.wr1_addr);
  assign resv_ok = bus.resv_en && !busy && !is_r0(bus.resv_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RF_IDLE: begin
        if (bus.clr_req) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      RF_CLEAR: begin
        if (idx_q == '1) begin
          state_d = RF_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = RF_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Port 1 is applied last so it wins both data and pending on an address collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '0;
      pend_q <= '0;
    end else if (busy) begin
      mem_q[idx_q]  <= '0;
      pend_q[idx_q] <= 1'b0;
    end else begin
      if (wr0_ok) begin
        mem_q[bus.wr0_addr]  <= bus.wr0_data;
        pend_q[bus.wr0_addr] <= 1'b0;
      end
      if (wr1_ok) begin
        mem_q[bus.wr1_addr]  <= bus.wr1_data;
        pend_q[bus.wr1_addr] <= 1'b0;
      end
      if (resv_ok) begin
        pend_q[bus.resv_addr] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0),
      .BYPASS  (BYPASS),
      .DEPTH   (DEPTH)
    ) u_rd (
      .addr      (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .mem       (mem_q),
      .pend_vec  (pend_q),
      .wr0_en    (wr0_ok),
      .wr0_addr  (bus.wr0_addr),
      .wr0_data  (bus.wr0_data),
      .wr1_en    (wr1_ok),
      .wr1_addr  (bus.wr1_addr),
      .wr1_data  (bus.wr1_data),
      .resv_en   (resv_ok),
      .resv_addr (bus.resv_addr),
      .data      (bus.rd_data[k*DATA_W +: DATA_W]),
      .pend      (bus.rd_pend[k])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus queues expected read results, monitor checks at negedge.
module tb_reg_file_mp;

  logic clk;
  logic rst_n;

  reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  reg_file_mp #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .NUM_RD  (2),
    .ZERO_R0 (1),
    .BYPASS  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  pend;
    logic        busy;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.rd_data[31:0] !== e.d0 || bus.rd_data[63:32] !== e.d1 ||
          bus.rd_pend !== e.pend || bus.clr_busy !== e.busy) begin
        n_fail++;
        $display("FAIL %s: got d0=%h d1=%h pend=%b busy=%b, expected d0=%h d1=%h pend=%b busy=%b",
                 e.name, bus.rd_data[31:0], bus.rd_data[63:32], bus.rd_pend, bus.clr_busy,
                 e.d0, e.d1, e.pend, e.busy);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr0_en    = 1'b0;
    bus.wr0_addr  = '0;
    bus.wr0_data  = '0;
    bus.wr1_en    = 1'b0;
    bus.wr1_addr  = '0;
    bus.wr1_data  = '0;
    bus.resv_en   = 1'b0;
    bus.resv_addr = '0;
    bus.clr_req   = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    bus.wr0_en = 1'b1; bus.wr0_addr = a; bus.wr0_data = d;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d);
    bus.wr1_en = 1'b1; bus.wr1_addr = a; bus.wr1_data = d;
  endtask

  task automatic resv(input logic [4:0] a);
    bus.resv_en = 1'b1; bus.resv_addr = a;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] pend, input logic busy);
    exp_t e;
    e.d0 = d0; e.d1 = d1; e.pend = pend; e.busy = busy; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic scan_zero(input string name, input logic busy);
    for (int a = 0; a < 32; a += 2) begin
      cyc(); idle(); rd(5'(a), 5'(a + 1));
      expect_rd(name, 32'h0, 32'h0, 2'b00, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rd(5'd0, 5'd0);

    // Reset state
    cyc(); expect_rd("in_reset", 32'h0, 32'h0, 2'b00, 1'b0);
    cyc(); rst_n = 1'b1;
    scan_zero("reset_scan", 1'b0);

    // Dual write collision and bypass priority
    cyc(); idle(); wr0(5'd5, 32'h1234); wr1(5'd5, 32'hBEEF); rd(5'd5, 5'd5);
    expect_rd("byp_wr1_prio", 32'hBEEF, 32'hBEEF, 2'b00, 1'b0);
    cyc(); idle(); wr0(5'd6, 32'h1234); rd(5'd5, 5'd6);
    expect_rd("stored_wr1_byp_wr0", 32'hBEEF, 32'h1234, 2'b00, 1'b0);
    cyc(); idle(); rd(5'd6, 5'd5);
    expect_rd("stored_r6_r5", 32'h1234, 32'hBEEF, 2'b00, 1'b0);

    // r0 hardwired zero
    cyc(); idle(); wr0(5'd0, 32'hFFFF_FFFF); wr1(5'd0, 32'h0F0F); resv(5'd0); rd(5'd0, 5'd0);
    expect_rd("r0_same_cycle", 32'h0, 32'h0, 2'b00, 1'b0);
    cyc(); idle(); rd(5'd0, 5'd5);
    expect_rd("r0_after", 32'h0, 32'hBEEF, 2'b00, 1'b0);

    // Pending scoreboard
    cyc(); idle(); resv(5'd7); rd(5'd7, 5'd8);
    expect_rd("resv_same_cycle", 32'h0, 32'h0, 2'b00, 1'b0);
    cyc(); idle(); rd(5'd7, 5'd8);
    expect_rd("resv_visible", 32'h0, 32'h0, 2'b01, 1'b0);
    cyc(); idle(); wr0(5'd7, 32'h55); resv(5'd7); rd(5'd7, 5'd7);
    expect_rd("wr_resv_bypass", 32'h55, 32'h55, 2'b11, 1'b0);
    cyc(); idle(); rd(5'd7, 5'd8);
    expect_rd("wr_resv_stays", 32'h55, 32'h0, 2'b01, 1'b0);
    cyc(); idle(); wr1(5'd7, 32'h66); rd(5'd8, 5'd7);
    expect_rd("wr1_bypass_pend0", 32'h0, 32'h66, 2'b00, 1'b0);
    cyc(); idle(); rd(5'd7, 5'd7);
    expect_rd("wr_clears_pend", 32'h66, 32'h66, 2'b00, 1'b0);
    cyc(); idle(); resv(5'd9); rd(5'd9, 5'd9);
    expect_rd("resv9_first", 32'h0, 32'h0, 2'b00, 1'b0);
    cyc(); idle(); resv(5'd9); rd(5'd9, 5'd0);
    expect_rd("resv9_again", 32'h0, 32'h0, 2'b01, 1'b0);
    cyc(); idle(); rd(5'd9, 5'd9);
    expect_rd("resv9_held", 32'h0, 32'h0, 2'b11, 1'b0);

    // Fill, then bulk clear with traffic that must be dropped
    for (int a = 1; a < 32; a++) begin
      cyc(); idle(); wr0(5'(a), 32'h1000_0000 + a);
    end
    cyc(); idle(); resv(5'd12); rd(5'd1, 5'd31);
    expect_rd("fill_check", 32'h1000_0001, 32'h1000_001F, 2'b00, 1'b0);
    cyc(); idle(); bus.clr_req = 1'b1; rd(5'd12, 5'd9);
    expect_rd("clr_req_cycle", 32'h1000_000C, 32'h1000_0009, 2'b01, 1'b0);
    for (int c = 0; c < 32; c++) begin
      logic [31:0] e0, e1;
      cyc(); idle();
      wr0(5'(c), 32'hDEAD);
      wr1(5'(c - 1), 32'hBEEF);
      resv(5'(c - 1));
      bus.clr_req = (c == 16);
      rd(5'(c), 5'(c - 1));
      e0 = (c == 0) ? 32'h0 : 32'h1000_0000 + c;
      e1 = (c == 0) ? 32'h1000_001F : 32'h0;
      expect_rd("clear_step", e0, e1, {1'b0, c == 12}, 1'b1);
    end
    scan_zero("post_clear_scan", 1'b0);

    // Reset in the middle of a clear, then a fresh clear from idx 0
    cyc(); idle(); wr0(5'd20, 32'hAA);
    cyc(); idle(); bus.clr_req = 1'b1; rd(5'd0, 5'd20);
    expect_rd("clr2_req", 32'h0, 32'hAA, 2'b00, 1'b0);
    for (int c = 0; c < 10; c++) begin
      cyc(); idle(); rd(5'd0, 5'd20);
      expect_rd("clr2_step", 32'h0, 32'hAA, 2'b00, 1'b1);
    end
    cyc(); idle(); rd(5'd0, 5'd20); rst_n = 1'b0;
    expect_rd("reset_mid_clear", 32'h0, 32'h0, 2'b00, 1'b0);
    cyc(); idle(); rst_n = 1'b1; rd(5'd0, 5'd20);
    expect_rd("after_reset", 32'h0, 32'h0, 2'b00, 1'b0);
    cyc(); idle(); wr0(5'd20, 32'h77); rd(5'd0, 5'd20);
    expect_rd("refill_bypass", 32'h0, 32'h77, 2'b00, 1'b0);
    cyc(); idle(); bus.clr_req = 1'b1; rd(5'd0, 5'd20);
    expect_rd("clr3_req", 32'h0, 32'h77, 2'b00, 1'b0);
    for (int c = 0; c < 32; c++) begin
      cyc(); idle(); rd(5'd0, 5'd20);
      expect_rd("clr3_step", 32'h0, (c <= 20) ? 32'h77 : 32'h0, 2'b00, 1'b1);
    end
    cyc(); idle(); rd(5'd0, 5'd20);
    expect_rd("clr3_done", 32'h0, 32'h0, 2'b00, 1'b0);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
